fpu_mult_sched: RTL

FPU_MULT_SCHED -- requirements
Module: fpu_mult_sched

---
 rtl/fpu_mult_sched_if.sv | 60 ++++++
 rtl/fpu_mult_sched.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fpu_mult_sched_if.sv
// Bundle of all non-clock signals around the FP multiply scheduler.
//   req0_* / req1_* : two requester valid/ready channels (operands + tag)
//   mul_*           : shared combinational 24x24 mantissa multiplier
//   fm_*            : FP multiply normalisation unit
//   resp_*          : single response channel, sched_busy status
// Modport slave is the scheduler side, master is the surrounding environment.
interface fpu_mult_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_opa;
  logic [31:0] req0_opb;
  logic [3:0]  req0_tag;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_opa;
  logic [31:0] req1_opb;
  logic [3:0]  req1_tag;
  logic [23:0] mul_a;
  logic [23:0] mul_b;
  logic [47:0] mul_p;
  logic [31:0] fm_opa;
  logic [31:0] fm_opb;
  logic [47:0] fm_mult_result;
  logic        fm_new_input;
  logic [34:0] fm_out;
  logic        fm_busy;
  logic        resp_valid;
  logic        resp_ready;
  logic [34:0] resp_data;
  logic [3:0]  resp_tag;
  logic        resp_src;
  logic        resp_err;
  logic        sched_busy;

  modport slave (
    input  req0_valid, req0_opa, req0_opb, req0_tag,
    input  req1_valid, req1_opa, req1_opb, req1_tag,
    output req0_ready, req1_ready,
    output mul_a, mul_b,
    input  mul_p,
    output fm_opa, fm_opb, fm_mult_result, fm_new_input,
    input  fm_out, fm_busy,
    output resp_valid, resp_data, resp_tag, resp_src, resp_err,
    input  resp_ready,
    output sched_busy
  );

  modport master (
    output req0_valid, req0_opa, req0_opb, req0_tag,
    output req1_valid, req1_opa, req1_opb, req1_tag,
    input  req0_ready, req1_ready,
    input  mul_a, mul_b,
    output mul_p,
    input  fm_opa, fm_opb, fm_mult_result, fm_new_input,
    output fm_out, fm_busy,
    input  resp_valid, resp_data, resp_tag, resp_src, resp_err,
    output resp_ready,
    input  sched_busy
  );
endinterface

// File: rtl/fpu_mult_sched.sv
// Two-requester scheduler for a shared FP single-precision multiply path.
// Round-robin grants one operation at a time, feeds the shared mantissa
// multiplier and the FP multiply unit, waits for normalisation (with a
// timeout) and returns the result with the requester's tag and index.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fpu_mult_sched_if.slave (requests, multiplier, FP unit, response)
module fpu_mult_sched (
  input logic               clk,
  input logic               rst_n,
  fpu_mult_sched_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StNorm, StDone} state_e;

  localparam logic [5:0] NormTimeout = 6'd47;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [5:0]  norm_cnt_q, norm_cnt_d;
  logic [31:0] opa_q, opb_q;
  logic [3:0]  tag_q;
  logic        src_q;
  logic [34:0] resp_data_q;
  logic        resp_err_q, resp_err_d;

  logic grant_any, grant_idx;
  logic op_load, resp_load, new_input;
  logic ready0, ready1;

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_idx = ~last_grant_q;
    else                                  grant_idx = bus.req1_valid;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    norm_cnt_d   = norm_cnt_q;
    resp_err_d   = resp_err_q;
    op_load      = 1'b0;
    resp_load    = 1'b0;
    new_input    = 1'b0;
    ready0       = 1'b0;
    ready1       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          op_load      = 1'b1;
          last_grant_d = grant_idx;
          ready0       = ~grant_idx;
          ready1       = grant_idx;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        new_input  = 1'b1;
        norm_cnt_d = '0;
        state_d    = StNorm;
      end
      StNorm: begin
        if (!bus.fm_busy) begin
          resp_load  = 1'b1;
          resp_err_d = 1'b0;
          state_d    = StDone;
        end else if (norm_cnt_q == NormTimeout) begin
          // Unit never settled: hand back whatever it shows, flagged.
          resp_load  = 1'b1;
          resp_err_d = 1'b1;
          state_d    = StDone;
        end else begin
          norm_cnt_d = norm_cnt_q + 6'd1;
        end
      end
      StDone: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      norm_cnt_q   <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      tag_q        <= '0;
      src_q        <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      norm_cnt_q   <= norm_cnt_d;
      if (op_load) begin
        opa_q <= grant_idx ? bus.req1_opa : bus.req0_opa;
        opb_q <= grant_idx ? bus.req1_opb : bus.req0_opb;
        tag_q <= grant_idx ? bus.req1_tag : bus.req0_tag;
        src_q <= grant_idx;
      end
      if (resp_load) begin
        resp_data_q <= bus.fm_out;
        resp_err_q  <= resp_err_d;
      end
    end
  end

  // Ready is combinational off the inputs, so gate it while reset is held.
  assign bus.req0_ready = ready0 & rst_n;
  assign bus.req1_ready = ready1 & rst_n;

  // Hidden bit is 1 unless the exponent field is zero (zero/denormal).
  assign bus.mul_a          = {|opa_q[30:23], opa_q[22:0]};
  assign bus.mul_b          = {|opb_q[30:23], opb_q[22:0]};
  assign bus.fm_opa         = opa_q;
  assign bus.fm_opb         = opb_q;
  assign bus.fm_mult_result = bus.mul_p;
  assign bus.fm_new_input   = new_input;

  assign bus.resp_valid = (state_q == StDone);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = tag_q;
  assign bus.resp_src   = src_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.sched_busy = (state_q != StIdle);

endmodule
